// File: rtl/turbofm_pkg.sv
// Shared device codes, sequencer states and default bus timing for the YM/SAA local bus.
// Timing defaults assume a 56 MHz clk.
package turbofm_pkg;

    localparam logic [1:0] DEV_YM0 = 2'd0;
    localparam logic [1:0] DEV_YM1 = 2'd1;
    localparam logic [1:0] DEV_SAA = 2'd2;
    localparam logic [1:0] DEV_RSV = 2'd3;

    localparam int unsigned DEF_SETUP_CYC   = 2;
    localparam int unsigned DEF_STROBE_CYC  = 12;
    localparam int unsigned DEF_HOLD_CYC    = 2;
    localparam int unsigned DEF_RECOVER_CYC = 4;

    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    typedef struct packed {
        logic       wr;
        logic [1:0] dev;
        logic       a0;
        logic [7:0] wdata;
    } acc_t;

    // A state lasting n cycles loads n-1; a zero length is stretched to one cycle.
    function automatic logic [TMR_W-1:0] cyc_load(input int unsigned n);
        int unsigned m;
        m = (n == 0) ? 1 : n;
        return TMR_W'(m - 1);
    endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter; tc is high while the count is zero and the counter parks there.
// A load takes effect on the next clk edge and overrides counting.
module access_timer
    import turbofm_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/ym_access_seq.sv
// Sequences single YM2203/SAA bus accesses through setup/strobe/hold/recover with registered outputs.
// One access in flight; req_ready is high only in IDLE, so requesters wait out the full access.
module ym_access_seq
    import turbofm_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
    parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [1:0] req_dev,
    input  logic       req_a0,
    input  logic [7:0] req_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       yma0,
    output logic       ymcs0_n,
    output logic       ymcs1_n,
    output logic       ymrd_n,
    output logic       ymwr_n,
    output logic       saaa0,
    output logic       saacs_n,
    output logic       saawr_n
);

    localparam logic [TMR_W-1:0] LD_SETUP   = cyc_load(SETUP_CYC);
    localparam logic [TMR_W-1:0] LD_STROBE  = cyc_load(STROBE_CYC);
    localparam logic [TMR_W-1:0] LD_HOLD    = cyc_load(HOLD_CYC);
    localparam logic [TMR_W-1:0] LD_RECOVER = cyc_load(RECOVER_CYC);

    state_t            state, state_nxt;
    acc_t              cap, cap_nxt;
    logic              accept;
    logic              no_strobe;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_tc;
    logic              active_nxt;
    logic              strobe_nxt;
    logic              is_ym;
    logic              is_saa;

    access_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        accept  = req_valid && req_ready;
        cap_nxt = cap;
        if (accept) begin
            cap_nxt.wr    = req_wr;
            cap_nxt.dev   = req_dev;
            cap_nxt.a0    = req_a0;
            cap_nxt.wdata = req_wdata;
        end
        // SAA has no read strobe and the reserved code has no chip: skip straight to RECOVER.
        no_strobe = (cap_nxt.dev == DEV_RSV) || ((cap_nxt.dev == DEV_SAA) && !cap_nxt.wr);

        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    if (no_strobe) begin
                        state_nxt = ST_RECOVER;
                        tmr_val   = LD_RECOVER;
                    end else begin
                        state_nxt = ST_SETUP;
                        tmr_val   = LD_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_tc) begin
                    state_nxt = ST_STROBE;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_tc) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_tc) begin
                    state_nxt = ST_RECOVER;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (tmr_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        active_nxt = state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD};
        strobe_nxt = (state_nxt == ST_STROBE);
        is_ym      = (cap_nxt.dev == DEV_YM0) || (cap_nxt.dev == DEV_YM1);
        is_saa     = (cap_nxt.dev == DEV_SAA);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cap   <= '0;
        end else begin
            state <= state_nxt;
            cap   <= cap_nxt;
        end
    end

    // Pins are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            d_out     <= '0;
            d_oe      <= 1'b0;
            yma0      <= 1'b0;
            ymcs0_n   <= 1'b1;
            ymcs1_n   <= 1'b1;
            ymrd_n    <= 1'b1;
            ymwr_n    <= 1'b1;
            saaa0     <= 1'b0;
            saacs_n   <= 1'b1;
            saawr_n   <= 1'b1;
        end else begin
            req_ready <= (state_nxt == ST_IDLE);
            ymcs0_n   <= !(active_nxt && (cap_nxt.dev == DEV_YM0));
            ymcs1_n   <= !(active_nxt && (cap_nxt.dev == DEV_YM1));
            saacs_n   <= !(active_nxt && is_saa);
            yma0      <= active_nxt && is_ym && cap_nxt.a0;
            saaa0     <= active_nxt && is_saa && cap_nxt.a0;
            ymwr_n    <= !(strobe_nxt && is_ym && cap_nxt.wr);
            ymrd_n    <= !(strobe_nxt && is_ym && !cap_nxt.wr);
            saawr_n   <= !(strobe_nxt && is_saa && cap_nxt.wr);
            d_oe      <= active_nxt && cap_nxt.wr;
            d_out     <= (active_nxt && cap_nxt.wr) ? cap_nxt.wdata : '0;

            if ((state == ST_STROBE) && tmr_tc && !cap.wr) begin
                rd_valid <= 1'b1;
                rd_data  <= d_in;
            end else if (accept && no_strobe && !req_wr) begin
                rd_valid <= 1'b1;
                rd_data  <= 8'hFF;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule
